// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive bit decoder.
// Line-state classification helper lives here too.
package usb_rx_pkg;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;

  typedef enum logic [2:0] {
    IDLE, RECV, SE0_1, SE0_2, ERR
  } rx_state_t;

  localparam int BYTE_BITS_DEF = 8;
  localparam int STUFF_LEN_DEF = 6;

  function automatic line_state_t line_of(
    input logic dp,
    input logic dm
  );
    line_state_t l;
    case ({dp, dm})
      2'b10:   l = J;
      2'b01:   l = K;
      2'b00:   l = SE0;
      default: l = SE1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/usb_rx_bit_decoder_nrzi.sv
// NRZI line classifier: holds the previous J/K level and
// reports the decoded bit for the current sample.
module rx_nrzi_dec
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sample_en,
  input  logic        d_plus,
  input  logic        d_minus,
  output line_state_t line,
  output logic        dbit,
  output logic        is_se0,
  output logic        is_se1
);

  line_state_t prev_line;

  assign line   = line_of(d_plus, d_minus);
  assign is_se0 = (line == SE0);
  assign is_se1 = (line == SE1);
  assign dbit   = (line == prev_line);

  // Track the last J/K level; SE0/SE1 leave it untouched
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_line <= J;
    end else if (sample_en && (line == J || line == K)) begin
      prev_line <= line;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB RX NRZI decode, bit unstuff and EOP detect front end.
// Optional macro RX_STUFF_ERR_EN enables stuff_err and ERR state.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int BYTE_BITS = BYTE_BITS_DEF,
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sample_en,
  input  logic d_plus,
  input  logic d_minus,
  output logic serial_out,
  output logic shift_enable,
  output logic byte_done,
  output logic eop,
  output logic rx_active,
  output logic stuff_err
);

  localparam int BW = $clog2(BYTE_BITS);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(BYTE_BITS - 1);
  localparam logic [OW-1:0] SLEN = OW'(STUFF_LEN);

  line_state_t line;
  logic        dbit;
  logic        is_se0;
  logic        is_se1;

  rx_state_t   state, state_d;
  logic [OW-1:0] ones_cnt, ones_d;
  logic [BW-1:0] bit_cnt, bits_d;
  logic        err_se0, err_se0_d;
  logic        byte_pend;
  logic        so_d, se_d, wrap_d, eop_d, serr_d, act_d;
  logic        viol;

  rx_nrzi_dec u_nrzi (
    .clk       (clk),
    .n_rst     (n_rst),
    .sample_en (sample_en),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .line      (line),
    .dbit      (dbit),
    .is_se0    (is_se0),
    .is_se1    (is_se1)
  );

  // Next-state and output decode, evaluated only on bit strobes
  always_comb begin
    state_d   = state;
    ones_d    = ones_cnt;
    bits_d    = bit_cnt;
    err_se0_d = err_se0;
    so_d      = serial_out;
    se_d      = 1'b0;
    wrap_d    = 1'b0;
    eop_d     = 1'b0;
    serr_d    = 1'b0;
    act_d     = rx_active;
    viol      = 1'b0;
    if (sample_en && !is_se1) begin
      unique case (state)
        IDLE: begin
          if (line == K) begin
            state_d = RECV;
            se_d    = 1'b1;
            so_d    = 1'b0;
            bits_d  = BW'(1);
            ones_d  = '0;
            act_d   = 1'b1;
          end
        end
        RECV: begin
          if (is_se0) begin
            state_d = SE0_1;
          end else if (ones_cnt == SLEN) begin
            ones_d = '0;
`ifdef RX_STUFF_ERR_EN
            if (dbit) viol = 1'b1;
`endif
          end else begin
            se_d   = 1'b1;
            so_d   = dbit;
            ones_d = dbit ? ones_cnt + 1'b1 : '0;
            if (bit_cnt == LAST) begin
              bits_d = '0;
              wrap_d = 1'b1;
            end else begin
              bits_d = bit_cnt + 1'b1;
            end
          end
        end
        SE0_1: begin
          if (is_se0) state_d = SE0_2;
          else        viol    = 1'b1;
        end
        SE0_2: begin
          unique case (1'b1)
            (line == J): begin
              eop_d   = 1'b1;
              act_d   = 1'b0;
              ones_d  = '0;
              bits_d  = '0;
              state_d = IDLE;
            end
            (line == K): viol = 1'b1;
            default: ;
          endcase
        end
        ERR: begin
          if (is_se0) begin
            err_se0_d = 1'b1;
          end else if (line == J && err_se0) begin
            state_d = IDLE;
            ones_d  = '0;
            bits_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (viol) begin
      act_d  = 1'b0;
      ones_d = '0;
      bits_d = '0;
`ifdef RX_STUFF_ERR_EN
      serr_d    = 1'b1;
      err_se0_d = 1'b0;
      state_d   = ERR;
`else
      state_d = IDLE;
`endif
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      err_se0      <= 1'b0;
      byte_pend    <= 1'b0;
      serial_out   <= 1'b1;
      shift_enable <= 1'b0;
      byte_done    <= 1'b0;
      eop          <= 1'b0;
      rx_active    <= 1'b0;
      stuff_err    <= 1'b0;
    end else begin
      state        <= state_d;
      ones_cnt     <= ones_d;
      bit_cnt      <= bits_d;
      err_se0      <= err_se0_d;
      byte_pend    <= wrap_d;
      serial_out   <= so_d;
      shift_enable <= se_d;
      byte_done    <= byte_pend;
      eop          <= eop_d;
      rx_active    <= act_d;
      stuff_err    <= serr_d;
    end
  end

endmodule
